// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: opcodes, FSM states,
// ALU operation codes, operand selects and the opcode class bundle.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_ADR,
        S_EXEC_BR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_TRAP
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef struct packed {
        logic is_r;
        logic is_i;
        logic is_ld;
        logic is_st;
        logic is_br;
        logic is_illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier: exactly one class bit is set per opcode,
// anything not recognised lands in is_illegal.
module opcode_class_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_t  class_o
);

    // One-hot class lookup with illegal as the catch-all.
    always_comb begin
        class_o            = '0;
        class_o.is_r       = (opcode_i == OP_R);
        class_o.is_i       = (opcode_i == OP_I);
        class_o.is_ld      = (opcode_i == OP_LOAD);
        class_o.is_st      = (opcode_i == OP_STORE);
        class_o.is_br      = (opcode_i == OP_BRANCH);
        class_o.is_illegal = !(class_o.is_r | class_o.is_i | class_o.is_ld |
                               class_o.is_st | class_o.is_br);
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the RV32 datapath: FETCH/DECODE/EXEC/MEM/WB over a
// single memory port, with a memory wait timeout, sticky trap causes and a
// retired-instruction counter.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       Instruction_Opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             Branch,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       ALU_OpOut,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    // Counter only needs to reach MEM_TIMEOUT-1; with no timeout it just wraps.
    localparam int             TW         = $clog2(MEM_TIMEOUT + 2);
    localparam logic [TW-1:0]  WAIT_LAST  = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit             TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_e            state_q;
    logic              cls_st_q;     // latched "store" class, steers EXEC_ADR
    logic [TW-1:0]     wait_q;
    logic              illegal_q;
    logic              bus_err_q;
    logic [CNT_W-1:0]  instret_q;

    op_class_t         dec_cls;
    logic              in_mem;
    logic              wait_expired;
    logic              retire;

    opcode_class_decoder u_dec (
        .opcode_i (Instruction_Opcode),
        .class_o  (dec_cls)
    );

    assign in_mem       = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_LAST);
    assign retire       = (state_q == S_EXEC_BR) || (state_q == S_WB_ALU) ||
                          (state_q == S_WB_MEM)  || ((state_q == S_MEM_WR) && mem_ready);

    // Sequencer: phase transitions, then memory-wait/timeout, then retire bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cls_st_q  <= 1'b0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (run) begin
                    state_q <= S_FETCH;
                    wait_q  <= '0;
                end
                S_FETCH: if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    cls_st_q <= dec_cls.is_st;
                    if (dec_cls.is_illegal) begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else if (dec_cls.is_r)                  state_q <= S_EXEC_R;
                    else if (dec_cls.is_i)                      state_q <= S_EXEC_I;
                    else if (dec_cls.is_ld || dec_cls.is_st)    state_q <= S_EXEC_ADR;
                    else if (dec_cls.is_br)                     state_q <= S_EXEC_BR;
                end
                S_EXEC_R, S_EXEC_I: state_q <= S_WB_ALU;
                S_EXEC_ADR: begin
                    state_q <= cls_st_q ? S_MEM_WR : S_MEM_RD;
                    wait_q  <= '0;
                end
                S_MEM_RD: if (mem_ready) state_q <= S_WB_MEM;
                default: ;
            endcase

            // A ready in the last allowed cycle wins over the timeout.
            if (in_mem && !mem_ready) begin
                if (wait_expired) begin
                    state_q   <= S_TRAP;
                    bus_err_q <= 1'b1;
                end else begin
                    wait_q <= wait_q + TW'(1);
                end
            end

            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
                state_q   <= run ? S_FETCH : S_IDLE;
                wait_q    <= '0;
            end
        end
    end

    // Strobes decoded from the current phase; TRAP and IDLE drive nothing.
    always_comb begin
        mem_req   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        iord      = 1'b0;
        Branch    = 1'b0;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RS2;
        ALU_OpOut = ALU_ADD;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                MemRead   = 1'b1;
                alu_src_b = SRC_B_FOUR;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                ALU_OpOut = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                ALU_OpOut = ALU_FUNCT;
            end
            S_EXEC_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_EXEC_BR: begin
                alu_src_a = SRC_A_RS1;
                ALU_OpOut = ALU_SUB;
                Branch    = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                iord     = 1'b1;
            end
            S_WB_ALU: RegWrite = 1'b1;
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            default: ;
        endcase
    end

    // IR and PC load on the cycle the instruction word actually arrives.
    assign ir_write = (state_q == S_FETCH) && mem_ready;
    assign pc_write = (state_q == S_FETCH) && mem_ready;

    assign illegal  = illegal_q;
    assign bus_err  = bus_err_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its
// expected per-cycle strobe trace from its class and memory wait counts.
module tb_multicycle_control_fsm;

    localparam int CNT_W = 4;
    localparam int TO    = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic [6:0]       Instruction_Opcode = '0;
    logic             mem_ready = 1'b0;
    logic             mem_req, MemRead, MemWrite, iord, ir_write, pc_write, Branch;
    logic [1:0]       alu_src_a, alu_src_b, ALU_OpOut;
    logic             RegWrite, MemtoReg, illegal, bus_err;
    logic [CNT_W-1:0] instret;

    multicycle_control_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .Instruction_Opcode(Instruction_Opcode),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .Branch(Branch),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALU_OpOut(ALU_OpOut),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .illegal(illegal), .bus_err(bus_err),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0]      w;
        logic [CNT_W-1:0] cnt;
        logic             rdy;
        logic             rn;
        logic [6:0]       opc;
        string            tag;
    } cyc_t;

    cyc_t q[$];
    int   vecs = 0;
    int   miss = 0;
    int   m_cnt;
    bit   m_idle, m_ill, m_bus;

    function automatic logic [16:0] obs();
        return {mem_req, MemRead, MemWrite, iord, ir_write, pc_write, Branch,
                alu_src_a, alu_src_b, ALU_OpOut, RegWrite, MemtoReg, illegal, bus_err};
    endfunction

    // mr rd wr iord fetch-load branch a b op regwrite memtoreg
    function automatic logic [14:0] ow(bit mr, bit rd, bit wr, bit io, bit fl, bit br,
                                       logic [1:0] a, logic [1:0] b, logic [1:0] op,
                                       bit rw, bit m2r);
        return {mr, rd, wr, io, fl, fl, br, a, b, op, rw, m2r};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] ropc();
        return 7'($urandom);
    endfunction

    function automatic logic mid(bit rnd);
        return rnd ? 1'($urandom) : 1'b0;
    endfunction

    task automatic push(input logic [14:0] w, input logic rdy, input logic rn,
                        input logic [6:0] opc, input string tag);
        cyc_t c;
        c.w = {w, m_ill, m_bus};
        c.cnt = CNT_W'(m_cnt);
        c.rdy = rdy;
        c.rn = rn;
        c.opc = opc;
        c.tag = tag;
        q.push_back(c);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_idle = 1'b1;
        m_ill = 1'b0;
        m_bus = 1'b0;
        q.delete();
    endtask

    // Expected trace of one instruction; fw/mw = wait cycles before memory ready.
    task automatic add_instr(input logic [6:0] opc, input int fw, input int mw,
                             input bit run_after, input bit rnd_run);
        bit is_ld;
        if (m_idle) begin
            push('0, rb(), 1'b1, ropc(), "idle");
            m_idle = 1'b0;
        end
        for (int i = 0; i < fw; i++) begin
            push(ow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0),
                 1'b0, mid(rnd_run), ropc(), "fetch_wait");
            if (i == TO - 1) begin
                m_bus = 1'b1;
                return;
            end
        end
        push(ow(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0),
             1'b1, mid(rnd_run), ropc(), "fetch");
        push(ow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0),
             rb(), mid(rnd_run), opc, "decode");
        case (opc)
            OP_R, OP_I: begin
                push(ow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01,
                        (opc == OP_R) ? 2'b00 : 2'b10, 2'b10, 1'b0, 1'b0),
                     rb(), mid(rnd_run), ropc(), "exec_ri");
                push(ow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0),
                     rb(), run_after, ropc(), "wb_alu");
            end
            OP_LOAD, OP_STORE: begin
                is_ld = (opc == OP_LOAD);
                push(ow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0),
                     rb(), mid(rnd_run), ropc(), "exec_adr");
                for (int i = 0; i < mw; i++) begin
                    push(ow(1'b1, is_ld, !is_ld, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0),
                         1'b0, mid(rnd_run), ropc(), "mem_wait");
                    if (i == TO - 1) begin
                        m_bus = 1'b1;
                        return;
                    end
                end
                if (is_ld) begin
                    push(ow(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0),
                         1'b1, mid(rnd_run), ropc(), "mem_rd");
                    push(ow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1),
                         rb(), run_after, ropc(), "wb_mem");
                end else begin
                    push(ow(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0),
                         1'b1, run_after, ropc(), "mem_wr");
                end
            end
            OP_BRANCH:
                push(ow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0),
                     rb(), run_after, ropc(), "exec_br");
            default: begin
                m_ill = 1'b1;
                return;
            end
        endcase
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_idle = !run_after;
    endtask

    task automatic add_trap(input int n);
        for (int i = 0; i < n; i++) push('0, rb(), rb(), ropc(), "trap");
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push('0, rb(), 1'b0, ropc(), "idle_hold");
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        #2;
        vecs++;
        if ({obs(), instret} !== '0) begin
            miss++;
            $display("FAIL reset_state: outputs %h instret %0d, expected all zero", obs(), instret);
        end
        @(posedge clk);
        #1;
        vecs++;
        if ({obs(), instret} !== '0) begin
            miss++;
            $display("FAIL reset_held: outputs %h instret %0d, expected all zero", obs(), instret);
        end
        reset = 1'b1;
        model_reset();
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        vecs++;
        if ({mem_req, MemRead, MemWrite} !== 3'b110) begin
            miss++;
            $display("FAIL fetch_before_reset: req/rd/wr %b, expected 110", {mem_req, MemRead, MemWrite});
        end
        #1 reset = 1'b0;
        #1;
        vecs++;
        if ({obs(), instret} !== '0) begin
            miss++;
            $display("FAIL reset_mid_fetch: outputs %h instret %0d, expected all zero", obs(), instret);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        run = 1'b0;
        model_reset();
    endtask

    task automatic test_rtype();
        add_instr(OP_R, 0, 0, 1'b0, 1'b1);
        add_idle(2);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL rtype/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_wait();
        add_instr(OP_LOAD, 0, 3, 1'b0, 1'b1);
        add_instr(OP_I, 2, 0, 1'b0, 1'b1);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL load/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store_branch();
        add_instr(OP_STORE, 1, 2, 1'b1, 1'b1);
        add_instr(OP_BRANCH, 0, 0, 1'b0, 1'b1);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL st_br/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        add_instr(7'b1111111, 1, 0, 1'b1, 1'b1);
        add_trap(20);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL illegal/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        vecs++;
        if ({obs(), instret} !== '0) begin
            miss++;
            $display("FAIL trap_reset: outputs %h instret %0d, expected all zero", obs(), instret);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        run = 1'b0;
        model_reset();
    endtask

    task automatic test_timeout();
        add_instr(OP_R, TO, 0, 1'b1, 1'b1);
        add_trap(5);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL timeout_fetch/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
        apply_reset();
        add_instr(OP_R, TO - 1, 0, 1'b1, 1'b1);
        add_instr(OP_LOAD, TO - 1, TO - 1, 1'b1, 1'b1);
        add_instr(OP_STORE, 0, TO, 1'b1, 1'b1);
        add_trap(4);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL timeout_edge/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
        apply_reset();
    endtask

    task automatic test_run_wrap();
        add_instr(OP_R, 0, 0, 1'b0, 1'b0);
        add_idle(3);
        for (int i = 0; i < 16; i++) add_instr(OP_I, 0, 0, 1'b1, 1'b1);
        add_instr(OP_BRANCH, 0, 0, 1'b0, 1'b1);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL run_wrap/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [6:0] opc;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: opc = OP_R;
                1: opc = OP_I;
                2: opc = OP_LOAD;
                3: opc = OP_STORE;
                default: opc = OP_BRANCH;
            endcase
            add_instr(opc, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), rb(), 1'b1);
            if (m_idle && ($urandom_range(0, 1) == 1)) add_idle($urandom_range(1, 3));
        end
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.rdy; run = c.rn; Instruction_Opcode = c.opc;
            @(negedge clk);
            vecs++;
            if ({obs(), instret} !== {c.w, c.cnt}) begin
                miss++;
                $display("FAIL random/%s: got %h instret %0d, want %h instret %0d", c.tag, obs(), instret, c.w, c.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_branch();
        test_illegal();
        test_timeout();
        test_run_wrap();
        apply_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
